// File: rtl/wb_trace_buffer.sv
// Writeback trace buffer: snoops regfile writes into a timestamped circular
// buffer with trigger, stop/wrap modes and a first-word-fall-through pop port.
//
// Ports:
//   clock, reset (async active-low)
//   wb_en/wb_reg/wb_data  : snooped regfile write port
//   arm/stop              : capture session control pulses
//   cfg_wrap/cfg_trig_en/cfg_trig_reg : latched on arm
//   rd_en, rd_valid, rd_reg/rd_data/rd_ts : pop port, oldest entry
//   count, overflow, state : status
module wb_trace_buffer #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DEPTH          = 16,
  parameter int TS_WIDTH       = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      wb_en,
  input  logic [REG_ADDR_WIDTH-1:0] wb_reg,
  input  logic [DATA_WIDTH-1:0]     wb_data,
  input  logic                      arm,
  input  logic                      stop,
  input  logic                      cfg_wrap,
  input  logic                      cfg_trig_en,
  input  logic [REG_ADDR_WIDTH-1:0] cfg_trig_reg,
  input  logic                      rd_en,
  output logic                      rd_valid,
  output logic [REG_ADDR_WIDTH-1:0] rd_reg,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic [TS_WIDTH-1:0]       rd_ts,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic [1:0]                state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ARMED = 2'b01,
    S_CAP   = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  state_e                    state_q, state_d;
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      ovf_q, ovf_d;
  logic [TS_WIDTH-1:0]       ts_q, ts_d;
  logic                      wrap_q, wrap_d;
  logic [REG_ADDR_WIDTH-1:0] trig_q, trig_d;

  logic [REG_ADDR_WIDTH-1:0] reg_mem  [DEPTH];
  logic [DATA_WIDTH-1:0]     data_mem [DEPTH];
  logic [TS_WIDTH-1:0]       ts_mem   [DEPTH];

  logic qual;
  logic pop;
  logic full;
  logic push;
  logic push_en;

  assign qual = wb_en && (wb_reg != '0);
  assign pop  = rd_en && (cnt_q != '0);
  assign full = (cnt_q == FULL_C);

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    ts_d     = ts_q + TS_WIDTH'(1);
    wrap_d   = wrap_q;
    trig_d   = trig_q;
    push     = 1'b0;
    push_en  = 1'b0;
    if (arm) begin
      wrap_d   = cfg_wrap;
      trig_d   = cfg_trig_reg;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
      ts_d     = '0;
      state_d  = cfg_trig_en ? S_ARMED : S_CAP;
    end else begin
      unique case (state_q)
        S_ARMED: begin
          // the triggering write is itself entry 0
          if (qual && wb_reg == trig_q) begin
            push    = 1'b1;
            state_d = S_CAP;
          end
          if (stop) state_d = S_DONE;
        end
        S_CAP: begin
          push = qual;
          if (stop) state_d = S_DONE;
        end
        default: ;
      endcase
      // a simultaneous pop frees a slot, so no overwrite is needed
      push_en = push && (!full || wrap_q || pop);
      if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (push_en && full && !pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        ovf_d    = 1'b1;
      end else begin
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push_en && !pop) cnt_d = cnt_q + CNT_W'(1);
        else if (!push_en && pop) cnt_d = cnt_q - CNT_W'(1);
      end
      if (push_en && !pop && !wrap_q &&
          cnt_q == FULL_C - CNT_W'(1))
        state_d = S_DONE;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      ts_q     <= '0;
      wrap_q   <= 1'b0;
      trig_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      ts_q     <= ts_d;
      wrap_q   <= wrap_d;
      trig_q   <= trig_d;
    end
  end

  // storage needs no reset; rd_valid masks stale contents
  always_ff @(posedge clock) begin
    if (push_en) begin
      reg_mem[wr_ptr_q]  <= wb_reg;
      data_mem[wr_ptr_q] <= wb_data;
      ts_mem[wr_ptr_q]   <= ts_q;
    end
  end

  assign rd_valid = (cnt_q != '0);
  assign rd_reg   = rd_valid ? reg_mem[rd_ptr_q]  : '0;
  assign rd_data  = rd_valid ? data_mem[rd_ptr_q] : '0;
  assign rd_ts    = rd_valid ? ts_mem[rd_ptr_q]   : '0;
  assign count    = cnt_q;
  assign overflow = ovf_q;
  assign state    = state_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Testbench for wb_trace_buffer (DEPTH=4): vector table plus scoreboard
// of expected captured entries, drained through the pop port.
module tb_wb_trace_buffer;

  logic        clock;
  logic        reset;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        arm;
  logic        stop;
  logic        cfg_wrap;
  logic        cfg_trig_en;
  logic [4:0]  cfg_trig_reg;
  logic        rd_en;
  logic        rd_valid;
  logic [4:0]  rd_reg;
  logic [31:0] rd_data;
  logic [15:0] rd_ts;
  logic [2:0]  count;
  logic        overflow;
  logic [1:0]  state;

  wb_trace_buffer #(
    .DATA_WIDTH(32),
    .REG_ADDR_WIDTH(5),
    .DEPTH(4),
    .TS_WIDTH(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .wb_en(wb_en),
    .wb_reg(wb_reg),
    .wb_data(wb_data),
    .arm(arm),
    .stop(stop),
    .cfg_wrap(cfg_wrap),
    .cfg_trig_en(cfg_trig_en),
    .cfg_trig_reg(cfg_trig_reg),
    .rd_en(rd_en),
    .rd_valid(rd_valid),
    .rd_reg(rd_reg),
    .rd_data(rd_data),
    .rd_ts(rd_ts),
    .count(count),
    .overflow(overflow),
    .state(state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit          arm;
    bit          stop;
    bit          wrap;
    bit          trg;
    logic [4:0]  treg;
    bit          en;
    logic [4:0]  r;
    logic [31:0] d;
    bit          rd;
    bit          cap;
    bit          drn;
    int          cnt;
    logic [1:0]  st;
    bit          ov;
  } vec_t;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
    logic [15:0] t;
  } ent_t;

  vec_t vq[$];
  ent_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   exp_ts = 0;

  function automatic vec_t mk(bit a, bit s, bit w, bit tg,
                              logic [4:0] tr, bit en,
                              logic [4:0] r, logic [31:0] d,
                              bit rd, bit cap, bit drn, int cnt,
                              logic [1:0] st, bit ov);
    vec_t v;
    v.arm = a; v.stop = s; v.wrap = w; v.trg = tg; v.treg = tr;
    v.en = en; v.r = r; v.d = d; v.rd = rd; v.cap = cap;
    v.drn = drn; v.cnt = cnt; v.st = st; v.ov = ov;
    return v;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(bit was_arm);
    @(posedge clock);
    #1;
    if (was_arm) exp_ts = 0;
    else exp_ts++;
  endtask

  task automatic idle_in();
    arm = 0; stop = 0; wb_en = 0; rd_en = 0;
    wb_reg = '0; wb_data = '0;
  endtask

  task automatic cmp_head(string tag, ent_t e);
    chk({tag, " rd_valid"}, 64'(rd_valid), 64'd1);
    chk({tag, " rd_reg"}, 64'(rd_reg), 64'(e.r));
    chk({tag, " rd_data"}, 64'(rd_data), 64'(e.d));
    chk({tag, " rd_ts"}, 64'(rd_ts), 64'(e.t));
  endtask

  task automatic drain(string tag);
    int guard;
    ent_t e;
    guard = 0;
    idle_in();
    while (sb.size() > 0 && guard < 8) begin
      e = sb.pop_front();
      cmp_head($sformatf("%s pop%0d", tag, guard), e);
      rd_en = 1;
      tick(0);
      rd_en = 0;
      guard++;
    end
    if (sb.size() > 0)
      chk({tag, " drain bound"}, 64'(sb.size()), 64'd0);
    chk({tag, " drained count"}, 64'(count), 64'd0);
    chk({tag, " drained rd_valid"}, 64'(rd_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    ent_t e;
    reset = 0;
    cfg_wrap = 0; cfg_trig_en = 0; cfg_trig_reg = '0;
    idle_in();
    tick(0); tick(0);
    reset = 1;
    tick(0);

    // reset mid-capture aborts at once
    arm = 1; tick(1); arm = 0;
    wb_en = 1; wb_reg = 5'd1; wb_data = 32'h55;
    tick(0); tick(0);
    wb_en = 0;
    chk("pre-reset count", 64'(count), 64'd2);
    #2 reset = 0;
    #1;
    chk("async state", 64'(state), 64'd0);
    chk("async count", 64'(count), 64'd0);
    chk("async rd_valid", 64'(rd_valid), 64'd0);
    tick(0);
    reset = 1;
    wb_en = 1; wb_reg = 5'd3; wb_data = 32'h11;
    tick(0);
    idle_in();
    chk("idle state", 64'(state), 64'd0);
    chk("idle count", 64'(count), 64'd0);
    chk("idle overflow", 64'(overflow), 64'd0);
    chk("idle rd_valid", 64'(rd_valid), 64'd0);
    chk("idle rd_reg", 64'(rd_reg), 64'd0);
    chk("idle rd_data", 64'(rd_data), 64'd0);
    chk("idle rd_ts", 64'(rd_ts), 64'd0);

    // stop mode: fills at r4, r5 dropped, r0 never stored
    vq.push_back(mk(1,0,0,0,0, 0,0,0,      0,0,0, 0,2'b10,0));
    vq.push_back(mk(0,0,0,0,0, 1,1,'hA1,   0,1,0, 1,2'b10,0));
    vq.push_back(mk(0,0,0,0,0, 1,0,'hFF,   0,0,0, 1,2'b10,0));
    vq.push_back(mk(0,0,0,0,0, 1,2,'hA2,   0,1,0, 2,2'b10,0));
    vq.push_back(mk(0,0,0,0,0, 1,3,'hA3,   0,1,0, 3,2'b10,0));
    vq.push_back(mk(0,0,0,0,0, 1,4,'hA4,   0,1,0, 4,2'b11,0));
    vq.push_back(mk(0,0,0,0,0, 1,5,'hA5,   0,0,1, 4,2'b11,0));
    vq.push_back(mk(0,0,0,0,0, 0,0,0,      1,0,0, 0,2'b11,0));
    // wrap mode: six writes keep r3..r6, overflow set
    vq.push_back(mk(1,0,1,0,0, 0,0,0,      0,0,0, 0,2'b10,0));
    vq.push_back(mk(0,0,0,0,0, 1,1,'hB1,   0,0,0, 1,2'b10,0));
    vq.push_back(mk(0,0,0,0,0, 1,2,'hB2,   0,0,0, 2,2'b10,0));
    vq.push_back(mk(0,0,0,0,0, 1,3,'hB3,   0,1,0, 3,2'b10,0));
    vq.push_back(mk(0,0,0,0,0, 1,4,'hB4,   0,1,0, 4,2'b10,0));
    vq.push_back(mk(0,0,0,0,0, 1,5,'hB5,   0,1,0, 4,2'b10,1));
    vq.push_back(mk(0,0,0,0,0, 1,6,'hB6,   0,1,1, 4,2'b10,1));
    // trigger on r7, then stop; writes in DONE ignored
    vq.push_back(mk(1,0,0,1,7, 0,0,0,      0,0,0, 0,2'b01,0));
    vq.push_back(mk(0,0,0,0,0, 1,2,'h22,   0,0,0, 0,2'b01,0));
    vq.push_back(mk(0,0,0,0,0, 1,7,'h77,   0,1,0, 1,2'b10,0));
    vq.push_back(mk(0,0,0,0,0, 1,8,'h88,   0,1,0, 2,2'b10,0));
    vq.push_back(mk(0,1,0,0,0, 0,0,0,      0,0,0, 2,2'b11,0));
    vq.push_back(mk(0,0,0,0,0, 1,9,'h99,   0,0,1, 2,2'b11,0));
    // push and pop together at full in wrap mode
    vq.push_back(mk(1,0,1,0,0, 0,0,0,      0,0,0, 0,2'b10,0));
    vq.push_back(mk(0,0,0,0,0, 1,1,'hC1,   0,1,0, 1,2'b10,0));
    vq.push_back(mk(0,0,0,0,0, 1,2,'hC2,   0,1,0, 2,2'b10,0));
    vq.push_back(mk(0,0,0,0,0, 1,3,'hC3,   0,1,0, 3,2'b10,0));
    vq.push_back(mk(0,0,0,0,0, 1,4,'hC4,   0,1,0, 4,2'b10,0));
    vq.push_back(mk(0,0,0,0,0, 1,5,'hC5,   1,1,1, 4,2'b10,0));
    // arm and stop together in capture: arm wins, ts restarts
    vq.push_back(mk(1,0,0,0,0, 0,0,0,      0,0,0, 0,2'b10,0));
    vq.push_back(mk(0,0,0,0,0, 1,1,'hD1,   0,1,0, 1,2'b10,0));
    vq.push_back(mk(0,0,0,0,0, 1,2,'hD2,   0,1,0, 2,2'b10,0));
    vq.push_back(mk(0,0,0,0,0, 1,3,'hD3,   0,1,0, 3,2'b10,0));
    vq.push_back(mk(1,1,0,0,0, 0,0,0,      0,0,0, 0,2'b10,0));
    vq.push_back(mk(0,0,0,0,0, 1,4,'hD4,   0,1,1, 1,2'b10,0));

    foreach (vq[i]) begin
      v = vq[i];
      arm = v.arm; stop = v.stop;
      cfg_wrap = v.wrap; cfg_trig_en = v.trg; cfg_trig_reg = v.treg;
      wb_en = v.en; wb_reg = v.r; wb_data = v.d;
      rd_en = v.rd;
      if (v.rd && sb.size() > 0) begin
        e = sb.pop_front();
        cmp_head($sformatf("row%0d head", i), e);
      end
      if (v.arm) sb.delete();
      if (v.cap) begin
        e.r = v.r; e.d = v.d; e.t = exp_ts[15:0];
        sb.push_back(e);
      end
      tick(v.arm);
      idle_in();
      chk($sformatf("row%0d count", i), 64'(count), 64'(v.cnt));
      chk($sformatf("row%0d state", i), 64'(state), 64'(v.st));
      chk($sformatf("row%0d overflow", i), 64'(overflow), 64'(v.ov));
      chk($sformatf("row%0d rd_valid", i), 64'(rd_valid),
          64'(v.cnt != 0));
      if (v.drn) drain($sformatf("row%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_trace_buffer.md
# wb_trace_buffer

Parametrised writeback trace buffer that sits beside the processor/regfile pair in the top-level wrapper and snoops the regfile write port (enable, register, data). The single-value writeback debug outputs become a captured history. Qualifying writes are stored, each with a cycle timestamp, in a DEPTH-entry circular buffer. Capture supports an optional register-match trigger and stop-when-full or wrap-around modes. A first-word-fall-through pop port lets the bench or a debug UART drain the buffer.

## Interface
Parameters:
- DATA_WIDTH, 32, width of captured writeback data
- REG_ADDR_WIDTH, 5, width of register index
- DEPTH, 16, buffer entries; power of two, at least 2
- TS_WIDTH, 16, timestamp counter width

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- wb_en  in  1  regfile write enable (from ctrl_writeEnable)
- wb_reg  in  REG_ADDR_WIDTH  register being written
- wb_data  in  DATA_WIDTH  data being written
- arm  in  1  pulse; clears buffer and starts a capture session
- stop  in  1  pulse; ends capture
- cfg_wrap  in  1  sampled at arm: 0 = stop when full, 1 = wrap and overwrite oldest
- cfg_trig_en  in  1  sampled at arm: 1 = wait for trigger before capturing
- cfg_trig_reg  in  REG_ADDR_WIDTH  sampled at arm: trigger register index
- rd_en  in  1  pop oldest entry
- rd_valid  out  1  buffer non-empty
- rd_reg, rd_data, rd_ts  out  REG_ADDR_WIDTH / DATA_WIDTH / TS_WIDTH  oldest entry
- count  out  log2(DEPTH)+1  entries held
- overflow  out  1  sticky; set when an entry was overwritten in wrap mode
- state  out  2  00 IDLE, 01 ARMED, 10 CAPTURE, 11 DONE

## Operation
- Qualifying write: wb_en=1 and wb_reg != 0. Writes to register 0 are never captured and never trigger.
- Timestamp counter clears to 0 on arm and increments every cycle, wrapping modulo 2^TS_WIDTH. Each entry stores the counter value from its capture cycle.
- Arm: accepted in any state. It has priority over stop and rd_en in the same cycle. It does the following:
  - latches the cfg_* inputs;
  - clears the pointers, count and overflow;
  - enters ARMED if cfg_trig_en=1, otherwise CAPTURE.
- ARMED: a qualifying write with wb_reg == latched trig_reg moves the block to CAPTURE. That triggering write is itself captured as entry 0.
- CAPTURE: every qualifying write is pushed.
  - Stop mode: the push that makes count == DEPTH also moves the block to DONE.
  - Wrap mode, full, no pop: the push overwrites the oldest entry, advances both pointers, keeps count = DEPTH and sets overflow.
  - Push and pop in the same cycle: both take effect, count is unchanged, no overwrite, overflow unaffected.
- Stop: from ARMED or CAPTURE goes to DONE. Ignored in IDLE and DONE. A write coincident with stop in CAPTURE is still captured.
- Pop: allowed in every state. rd_en with rd_valid=1 discards the oldest entry. rd_en with an empty buffer is ignored.
- DONE: no captures. Contents remain until popped or until the next arm.
- Pointers are log2(DEPTH) bits and wrap naturally. Full and empty are decided by count, not by pointer compare.

## Timing
- Reset (asynchronous, reset=0): state=IDLE, count=0, overflow=0, rd_valid=0, rd_reg=0, rd_data=0, rd_ts=0. Pointers, timestamp and latched cfg are all 0. Storage contents are don't-care but masked by rd_valid=0.
- A reset asserted mid-capture aborts it immediately. After reset deasserts, the block waits in IDLE for arm.
- Capture latency: a write sampled at edge N is visible on rd_* and count after edge N, provided it is the oldest entry.
- rd_* is fall-through: the oldest entry is driven from registers with no read latency. A pop at edge N presents the next entry after edge N.
- State transitions take effect on the same edge as the causing event. state reads the new value in the following cycle.
- Throughput: one capture and one pop per cycle, sustained.

## Test plan
- Reset/idle: reset low mid-stream then released; write r3=0x11 with no arm -> state=00, count=0, rd_valid=0, all rd_* are 0.
- Stop mode, DEPTH=4: arm (wrap=0, trig=0); writes r1..r5 = 0xA1..0xA5 on consecutive cycles, plus r0=0xFF in between -> count=4 and state=11 after the 4th write. Pops yield regs 1,2,3,4 with data 0xA1..0xA4. r5 is dropped and r0 is never stored.
- Wrap mode, DEPTH=4: arm (wrap=1); 6 writes r1..r6 -> count=4, overflow=1, pops yield r3..r6. rd_ts values are strictly increasing by the write spacing.
- Trigger: arm (trig_en=1, trig_reg=7); writes r2, r7=0x77, r8 -> state goes 01 then 10 on the r7 write. Entries are r7=0x77 then r8; r2 is absent.
- Simultaneous push/pop at full in wrap mode, DEPTH=4 -> count stays 4, overflow stays 0, popped entry is the oldest.
- Arm and stop together in CAPTURE with 3 entries -> arm wins: count=0, state=10, timestamp restarts at 0.
